// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit:
// funct3 op codes, FSM states, result-select codes and op decode helpers.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SEL_LO  = 2'd0,
    SEL_HI  = 2'd1,
    SEL_QUO = 2'd2,
    SEL_REM = 2'd3
  } sel_e;

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_signed1(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_signed2(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic sel_e op_sel(input logic [2:0] op);
    sel_e v_sel;
    case (op)
      OP_MUL:                       v_sel = SEL_LO;
      OP_MULH, OP_MULHSU, OP_MULHU: v_sel = SEL_HI;
      OP_DIV, OP_DIVU:              v_sel = SEL_QUO;
      OP_REM, OP_REMU:              v_sel = SEL_REM;
      default:                      v_sel = SEL_LO;
    endcase
    return v_sel;
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign handling: operand magnitudes on the request side and
// sign correction plus result selection on the completion side.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_op_req,
  input  logic [XLEN-1:0] i_data1,
  input  logic [XLEN-1:0] i_data2,
  input  logic [2:0]      i_op_res,
  input  logic            i_neg_res,
  input  logic            i_neg_rem,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  output logic [XLEN-1:0] o_mag_a,
  output logic [XLEN-1:0] o_mag_b,
  output logic            o_neg_res,
  output logic            o_neg_rem,
  output logic [XLEN-1:0] o_result
);

  logic              w_s1;
  logic              w_s2;
  logic [XLEN-1:0]   w_abs1;
  logic [XLEN-1:0]   w_abs2;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;

  // Divide keeps the divisor in the A register and the dividend in the shifting register
  always_comb begin
    w_s1      = op_signed1(i_op_req) & i_data1[XLEN-1];
    w_s2      = op_signed2(i_op_req) & i_data2[XLEN-1];
    w_abs1    = w_s1 ? (-i_data1) : i_data1;
    w_abs2    = w_s2 ? (-i_data2) : i_data2;
    o_mag_a   = op_is_div(i_op_req) ? w_abs2 : w_abs1;
    o_mag_b   = op_is_div(i_op_req) ? w_abs1 : w_abs2;
    o_neg_res = w_s1 ^ w_s2;
    o_neg_rem = w_s1;
  end

  // Remainder takes the dividend sign; quotient and product take the xor of signs
  always_comb begin
    w_prod     = {i_hi, i_lo};
    w_prod_fix = i_neg_res ? (-w_prod) : w_prod;
    o_result   = {XLEN{1'b0}};
    case (op_sel(i_op_res))
      SEL_LO:  o_result = w_prod_fix[XLEN-1:0];
      SEL_HI:  o_result = w_prod_fix[2*XLEN-1:XLEN];
      SEL_QUO: o_result = i_neg_res ? (-i_lo) : i_lo;
      SEL_REM: o_result = i_neg_rem ? (-i_hi) : i_hi;
      default: o_result = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit with valid/ready handshakes,
// divide fast paths and pipeline kill.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [2:0]      OP,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            KILL,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] RESULT
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  state_e          r_state;
  state_e          w_state_fsm;
  state_e          w_state_nxt;
  logic            w_accept;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic            r_neg_res;
  logic            r_neg_rem;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_result;
  logic            r_out_valid;
  logic            r_in_ready;

  logic            w_div0;
  logic            w_ovf;
  logic            w_fast;
  logic [XLEN-1:0] w_fast_res;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_rem_shift;
  logic [XLEN:0]   w_diff;
  logic [XLEN-1:0] w_hi_step;
  logic [XLEN-1:0] w_lo_step;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_neg_res;
  logic            w_neg_rem;
  logic [XLEN-1:0] w_fix_res;

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .i_op_req  (OP),
    .i_data1   (DATA1),
    .i_data2   (DATA2),
    .i_op_res  (r_op),
    .i_neg_res (r_neg_res),
    .i_neg_rem (r_neg_rem),
    .i_hi      (r_hi),
    .i_lo      (r_lo),
    .o_mag_a   (w_mag_a),
    .o_mag_b   (w_mag_b),
    .o_neg_res (w_neg_res),
    .o_neg_rem (w_neg_rem),
    .o_result  (w_fix_res)
  );

  // Divide-by-zero and signed overflow bypass the iteration; OP[1] marks the remainder ops
  always_comb begin
    w_div0     = op_is_div(OP) & (DATA2 == ZERO);
    w_ovf      = ((OP == OP_DIV) || (OP == OP_REM)) & (DATA1 == MINV) & (DATA2 == ONES);
    w_fast     = w_div0 | w_ovf;
    w_fast_res = w_div0 ? (OP[1] ? DATA1 : ONES) :
                 (w_ovf ? (OP[1] ? ZERO : DATA1) : ZERO);
  end

  // Next state; KILL overrides every other transition
  always_comb begin
    w_state_fsm = r_state;
    case (r_state)
      S_IDLE:  w_state_fsm = (r_in_ready && IN_VALID) ? (w_fast ? S_DONE : S_CALC) : S_IDLE;
      S_CALC:  w_state_fsm = (r_cnt == {CW{1'b0}}) ? S_FIX : S_CALC;
      S_FIX:   w_state_fsm = S_DONE;
      S_DONE:  w_state_fsm = OUT_READY ? S_IDLE : S_DONE;
      default: w_state_fsm = S_IDLE;
    endcase
    w_state_nxt = KILL ? S_IDLE : w_state_fsm;
    w_accept    = (r_state == S_IDLE) && r_in_ready && IN_VALID && !KILL;
  end

  // One radix-2 step: shift-add multiply or restoring divide on magnitudes
  always_comb begin
    w_sum       = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(XLEN+1){1'b0}});
    w_rem_shift = {r_hi, r_lo[XLEN-1]};
    w_diff      = w_rem_shift - {1'b0, r_a};
    w_hi_step   = r_hi;
    w_lo_step   = r_lo;
    if (op_is_div(r_op)) begin
      if (!w_diff[XLEN]) begin
        w_hi_step = w_diff[XLEN-1:0];
        w_lo_step = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_hi_step = w_rem_shift[XLEN-1:0];
        w_lo_step = {r_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      w_hi_step = w_sum[XLEN:1];
      w_lo_step = {w_sum[0], r_lo[XLEN-1:1]};
    end
  end

  // FSM state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture, iteration registers and registered handshake outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_op        <= 3'd0;
      r_a         <= ZERO;
      r_hi        <= ZERO;
      r_lo        <= ZERO;
      r_neg_res   <= 1'b0;
      r_neg_rem   <= 1'b0;
      r_cnt       <= {CW{1'b0}};
      r_result    <= ZERO;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_op      <= OP;
        r_a       <= w_mag_a;
        r_lo      <= w_mag_b;
        r_hi      <= ZERO;
        r_neg_res <= w_neg_res;
        r_neg_rem <= w_neg_rem;
        r_cnt     <= CW'(XLEN-1);
        if (w_fast) begin
          r_result <= w_fast_res;
        end
      end else if ((r_state == S_CALC) && !KILL) begin
        r_hi <= w_hi_step;
        r_lo <= w_lo_step;
        if (r_cnt != {CW{1'b0}}) begin
          r_cnt <= r_cnt - CW'(1);
        end
      end else if ((r_state == S_FIX) && !KILL) begin
        r_result <= w_fix_res;
      end
    end
  end

  assign IN_READY  = r_in_ready;
  assign OUT_VALID = r_out_valid;
  assign RESULT    = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (XLEN=32): results, latencies,
// fast paths, kill/reset abort and output backpressure.
module tb_muldiv_unit;

  localparam int XLEN = 32;
  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      op = 3'd0;
  logic [XLEN-1:0] d1 = 32'd0;
  logic [XLEN-1:0] d2 = 32'd0;
  logic            kill = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .CLK       (clk),
    .RESET     (rst),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .OP        (op),
    .DATA1     (d1),
    .DATA2     (d2),
    .KILL      (kill),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .RESULT    (result)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Drive a request at the falling edge; returns just after the accept edge
  task automatic start_op(input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    @(negedge clk);
    op = o; d1 = a; d2 = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Latency counts the accept edge as 1; bounded at 100 edges
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp_res, input int exp_lat);
    int lat;
    check_val({tag, "_rdy"}, in_ready, 1);
    start_op(o, a, b);
    wait_valid(lat);
    check_val({tag, "_lat"}, lat, exp_lat);
    check_val({tag, "_res"}, result, exp_res);
    consume();
    check_val({tag, "_vld_off"}, out_valid, 0);
  endtask

  task automatic watch_quiet(input string tag);
    logic seen;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check_val(tag, seen, 0);
  endtask

  initial begin
    int lat;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_vld", out_valid, 0);
    check_val("rst_res", result, 0);
    check_val("rst_rdy", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_val("rdy_after_rst", in_ready, 1);

    run_op("mul",    MUL,    32'h00000002, 32'h00000003, 32'h00000006, 34);
    run_op("mulh",   MULH,   32'hA0000002, 32'hB0000003, 32'h1DFFFFFE, 34);
    run_op("mulhsu", MULHSU, 32'h80000002, 32'h00000003, 32'hFFFFFFFE, 34);
    run_op("mulhu",  MULHU,  32'h80000002, 32'h00000003, 32'h00000001, 34);
    run_op("div",    DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34);
    run_op("rem",    REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34);
    run_op("divu",   DIVU,   32'h0000000A, 32'h00000002, 32'h00000005, 34);
    run_op("remu",   REMU,   32'h0000000B, 32'h00000003, 32'h00000002, 34);
    run_op("divu0",  DIVU,   32'h0000000A, 32'h00000000, 32'hFFFFFFFF, 1);
    run_op("remu0",  REMU,   32'h0000000A, 32'h00000000, 32'h0000000A, 1);
    run_op("divovf", DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("removf", REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

    // KILL ten cycles into a divide
    start_op(DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check_val("kill_rdy", in_ready, 1);
    check_val("kill_vld", out_valid, 0);
    watch_quiet("kill_quiet");

    // Reset in the middle of a multiply
    start_op(MUL, 32'd1234, 32'd5678);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("midrst_vld", out_valid, 0);
    check_val("midrst_res", result, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_val("midrst_rdy", in_ready, 1);
    watch_quiet("midrst_quiet");

    // Backpressure: hold OUT_READY low for five cycles
    start_op(MUL, 32'h00001234, 32'h00000010);
    wait_valid(lat);
    check_val("bp_lat", lat, 34);
    repeat (5) begin
      @(posedge clk);
      #1;
      check_val("bp_vld_hold", out_valid, 1);
      check_val("bp_res_hold", result, 32'h00012340);
    end
    consume();
    check_val("bp_vld_off", out_valid, 0);
    check_val("bp_rdy_back", in_ready, 1);
    op = MULHU; d1 = 32'h80000002; d2 = 32'h00000003; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_val("bp_next_accept", in_ready, 0);
    wait_valid(lat);
    check_val("bp_next_lat", lat, 34);
    check_val("bp_next_res", result, 32'h00000001);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the operand and result width (any even value from 8 to 64).
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port RESET, input, 1, an asynchronous active-high reset.
REQ-004 SHALL have port IN_VALID, input, 1, which marks a request on OP/DATA1/DATA2.
REQ-005 SHALL have port IN_READY, output, 1, which is high when the unit can accept a request.
REQ-006 SHALL have port OP, input, 3, the RV32M funct3 code: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 SHALL have ports DATA1 and DATA2, input, XLEN each, holding rs1 and rs2.
REQ-008 SHALL have port KILL, input, 1, a pipeline flush that aborts the operation in flight.
REQ-009 SHALL have port OUT_VALID, output, 1, which is high while RESULT is valid.
REQ-010 SHALL have port OUT_READY, input, 1, which the consumer drives high to accept RESULT.
REQ-011 SHALL have port RESULT, output, XLEN, the registered result.

Function
REQ-012 SHALL implement an FSM with states IDLE, CALC, FIX and DONE.
REQ-013 SHALL accept a request on an edge where IN_VALID and IN_READY are both high, and capture OP, DATA1 and DATA2 on that edge.
REQ-014 SHALL drive IN_READY high only in IDLE; a request cannot be accepted in the same cycle a result is consumed.
REQ-015 SHALL leave IDLE for CALC on a normal accept, with the iteration counter loaded to XLEN-1.
REQ-016 SHALL perform one radix-2 step per CALC cycle: shift-add for multiply, restoring shift-subtract for divide, both on operand magnitudes.
REQ-017 SHALL go from CALC to FIX when the counter reaches 0; FIX applies sign correction, selects the low or high product half or the quotient or remainder, registers RESULT, and goes to DONE.
REQ-018 SHALL hold OUT_VALID high in DONE and go to IDLE on the edge where OUT_READY is high.
REQ-019 SHALL give normal latency as follows: OUT_VALID rises XLEN+2 edges after the accept edge.
REQ-020 SHALL hold RESULT stable while OUT_VALID is high and OUT_READY is low.
REQ-021 SHALL apply these sign rules: MULH and DIV/REM are signed x signed; MULHSU is signed DATA1 x unsigned DATA2; MULHU, DIVU and REMU are unsigned.
REQ-022 SHALL make the remainder sign follow the dividend and truncate the quotient toward zero.
REQ-023 SHALL handle divide by zero via a fast path straight to DONE (OUT_VALID one edge after accept): quotient is all ones; remainder is DATA1.
REQ-024 SHALL handle signed overflow (DIV/REM of the most-negative value by -1) via the same fast path: quotient is DATA1; remainder is 0.
REQ-025 SHALL, when KILL is high, force IDLE on the next edge from any state, discard any pending result and deassert OUT_VALID.
REQ-026 SHALL give KILL priority over an accept or OUT_READY in the same cycle.

Reset
REQ-027 SHALL, on RESET high, asynchronously force state IDLE, OUT_VALID=0, RESULT=0, counter=0 and all operand registers to 0.
REQ-028 SHALL drive IN_READY=1 from the first edge after RESET is released.
REQ-029 SHALL discard an operation in flight when reset is asserted mid-operation; no result is produced.

Structure
REQ-030 SHALL place the OP encodings and FSM state encodings in the shared package/defines file alongside the ALU select codes.
REQ-031 SHALL use one sub-module, muldiv_sign_fix, which is combinational and holds the operand-magnitude and result-negation logic.

Verification
REQ-032 SHALL verify MUL (XLEN=32): DATA1=0x00000002, DATA2=0x00000003 -> RESULT=0x00000006, OUT_VALID rises 34 edges after accept.
REQ-033 SHALL verify the high-half multiplies:
- MULH a0000002*b0000003 -> 0x1DFFFFFE.
- MULHSU 80000002*00000003 -> 0xFFFFFFFE.
- MULHU 80000002*00000003 -> 0x00000001.
REQ-034 SHALL verify signed divide: DIV -7/2 -> 0xFFFFFFFD; REM -7,2 -> 0xFFFFFFFF; DIVU 0xA/0x2 -> 0x5; REMU 0xB,0x3 -> 0x2.
REQ-035 SHALL verify the fast paths: DIVU 0xA/0 -> 0xFFFFFFFF; REMU 0xA,0 -> 0xA; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; each with OUT_VALID one edge after accept.
REQ-036 SHALL verify KILL and reset abort: KILL 10 cycles into a DIV -> IDLE next edge, OUT_VALID stays 0, IN_READY=1; RESET asserted mid-MUL -> same.
REQ-037 SHALL verify backpressure: OUT_READY held low 5 cycles after OUT_VALID -> RESULT and OUT_VALID stable; on the OUT_READY edge -> IDLE, next request accepted one cycle later.
